// File: rtl/stream_credit_tx_pkg.sv
// Shared constants, packet layout and packet builder for the credit-based stream transmitter.
package stream_credit_tx_pkg;

    localparam int PACKET_BITS           = 97;
    localparam int NUM_LEAF_BITS         = 6;
    localparam int NUM_PORT_BITS         = 4;
    localparam int NUM_ADDR_BITS         = 7;
    localparam int PAYLOAD_BITS          = 64;
    localparam int FREESPACE_UPDATE_SIZE = 64;

    localparam int DEST_BITS   = NUM_LEAF_BITS + NUM_PORT_BITS;
    localparam int DEPTH       = 1 << NUM_ADDR_BITS;
    localparam int CREDIT_BITS = NUM_ADDR_BITS + 1;
    localparam int SUM_BITS    = NUM_ADDR_BITS + 2;
    localparam int VALID_IDX   = PACKET_BITS - 1;
    localparam int PAD_BITS    = PACKET_BITS - 1 - DEST_BITS - NUM_ADDR_BITS - PAYLOAD_BITS;

    localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = CREDIT_BITS'(DEPTH);

    // Field order from MSB down: valid, {leaf, port}, write address, zero pad, payload.
    typedef struct packed {
        logic                     valid;
        logic [DEST_BITS-1:0]     dest;
        logic [NUM_ADDR_BITS-1:0] addr;
        logic [PAD_BITS-1:0]      pad;
        logic [PAYLOAD_BITS-1:0]  payload;
    } pkt_t;

    function automatic pkt_t make_pkt(input logic [DEST_BITS-1:0]     dest,
                                      input logic [NUM_ADDR_BITS-1:0] addr,
                                      input logic [PAYLOAD_BITS-1:0]  payload);
        pkt_t p;
        p.valid   = 1'b1;
        p.dest    = dest;
        p.addr    = addr;
        p.pad     = '0;
        p.payload = payload;
        return p;
    endfunction

endpackage

// File: rtl/stream_credit_tx_fifo.sv
// Two-entry payload FIFO with full/empty flags; registered output, so a word can be read the cycle after it is written.
module stream_credit_tx_fifo #(
    parameter int WIDTH = 64
) (
    input  logic             clk_bft,
    input  logic             reset_bft,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;

    // NOTE: storage is deliberately not reset; count alone decides which entries are valid.
    always_ff @(posedge clk_bft) begin
        if (push) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_bft or negedge reset_bft) begin
        if (!reset_bft) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/stream_credit_tx.sv
// Credit-based stream transmitter: wraps user words into addressed packets, gated by receiver free space.
// Optional CREDIT_OVERFLOW_CHECK_EN adds a sticky err_credit_ovf output.
module stream_credit_tx
    import stream_credit_tx_pkg::*;
(
    input  logic                   clk_bft,
    input  logic                   reset_bft,
    input  logic [DEST_BITS-1:0]   cfg_dest,
    input  logic                   cfg_en,
    input  logic [PAYLOAD_BITS-1:0] din_user2tx,
    input  logic                   vld_user2tx,
    output logic                   ack_tx2user,
    input  logic [PACKET_BITS-1:0] credit_in,
    output logic [PACKET_BITS-1:0] pkt_out,
    output logic                   pkt_empty,
    input  logic                   pkt_rd,
`ifdef CREDIT_OVERFLOW_CHECK_EN
    output logic                   err_credit_ovf,
`endif
    output logic [CREDIT_BITS-1:0] credit_cnt
);

    logic [PAYLOAD_BITS-1:0]  fifo_dout;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     load;
    logic                     update;
    logic [NUM_ADDR_BITS-1:0] wr_addr;
    logic [SUM_BITS-1:0]      credit_sum;
    logic [CREDIT_BITS-1:0]   credit_next;
    pkt_t                     pkt_q;

    assign ack_tx2user = vld_user2tx & ~fifo_full;

    stream_credit_tx_fifo #(.WIDTH(PAYLOAD_BITS)) u_fifo (
        .clk_bft   (clk_bft),
        .reset_bft (reset_bft),
        .push      (ack_tx2user),
        .din       (din_user2tx),
        .pop       (load),
        .dout      (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A same-cycle update only shows up in credit_cnt next cycle, so C=0 blocks this load.
    assign load   = ~fifo_empty & (credit_cnt != '0) & cfg_en & (pkt_empty | pkt_rd);
    assign update = credit_in[VALID_IDX];

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        credit_sum  = SUM_BITS'(credit_cnt) - SUM_BITS'(load);
        credit_next = credit_sum[CREDIT_BITS-1:0];
        if (update) credit_sum = credit_sum + SUM_BITS'(FREESPACE_UPDATE_SIZE);
        if (credit_sum > SUM_BITS'(DEPTH)) credit_next = CREDIT_MAX;
        else                               credit_next = credit_sum[CREDIT_BITS-1:0];
    end

    always_ff @(posedge clk_bft or negedge reset_bft) begin
        if (!reset_bft) begin
            credit_cnt <= CREDIT_MAX;
            wr_addr    <= '0;
            pkt_q      <= '0;
            pkt_empty  <= 1'b1;
        end else begin
            credit_cnt <= credit_next;
            if (load) begin
                pkt_q     <= make_pkt(cfg_dest, wr_addr, fifo_dout);
                pkt_empty <= 1'b0;
                wr_addr   <= wr_addr + 1'b1;
            end else if (pkt_rd) begin
                pkt_empty <= 1'b1;
            end
        end
    end

    assign pkt_out = pkt_q;

`ifdef CREDIT_OVERFLOW_CHECK_EN
    always_ff @(posedge clk_bft or negedge reset_bft) begin
        if (!reset_bft)                          err_credit_ovf <= 1'b0;
        else if (credit_sum > SUM_BITS'(DEPTH))  err_credit_ovf <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_stream_credit_tx.sv
// Scoreboard bench for stream_credit_tx: accepted words are queued and matched against delivered packets.
module tb_stream_credit_tx;

    logic         clk_bft = 1'b0;
    logic         reset_bft;
    logic [9:0]   cfg_dest;
    logic         cfg_en;
    logic [63:0]  din_user2tx;
    logic         vld_user2tx;
    logic         ack_tx2user;
    logic [96:0]  credit_in;
    logic [96:0]  pkt_out;
    logic         pkt_empty;
    logic         pkt_rd;
    logic [7:0]   credit_cnt;
`ifdef CREDIT_OVERFLOW_CHECK_EN
    logic         err_credit_ovf;
`endif

    stream_credit_tx dut (
        .clk_bft        (clk_bft),
        .reset_bft      (reset_bft),
        .cfg_dest       (cfg_dest),
        .cfg_en         (cfg_en),
        .din_user2tx    (din_user2tx),
        .vld_user2tx    (vld_user2tx),
        .ack_tx2user    (ack_tx2user),
        .credit_in      (credit_in),
        .pkt_out        (pkt_out),
        .pkt_empty      (pkt_empty),
        .pkt_rd         (pkt_rd),
`ifdef CREDIT_OVERFLOW_CHECK_EN
        .err_credit_ovf (err_credit_ovf),
`endif
        .credit_cnt     (credit_cnt)
    );

    always #5 clk_bft = ~clk_bft;

    localparam logic [5:0]  LEAF   = 6'h2A;
    localparam logic [3:0]  PORT   = 4'h5;
    localparam logic [96:0] UPDATE = {1'b1, 96'b0};

    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] sb[$];
    int          words_left  = 0;
    logic [63:0] next_word;
    int          exp_addr    = 0;
    int          pkts_seen   = 0;
    int          mark;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [96:0] exp_pkt(input int a, input logic [63:0] p);
        logic [6:0] a7;
        a7 = 7'(a);
        return {1'b1, LEAF, PORT, a7, 15'b0, p};
    endfunction

    // One clock cycle, entered and left at posedge+1: offer a word, record accepts, score deliveries.
    task automatic tick();
        vld_user2tx = (words_left > 0);
        din_user2tx = next_word;
        #2;
        if (vld_user2tx && ack_tx2user) begin
            sb.push_back(din_user2tx);
            words_left--;
            next_word = {$urandom, $urandom};
        end
        if (pkt_rd && !pkt_empty) begin
            if (sb.size() == 0) begin
                check("pkt_unexpected", 128'(pkt_empty), 128'd1);
            end else begin
                check("pkt", 128'(pkt_out), 128'(exp_pkt(exp_addr, sb.pop_front())));
                exp_addr = (exp_addr + 1) % 128;
                pkts_seen++;
            end
        end
        @(posedge clk_bft);
        #1;
    endtask

    initial begin
        reset_bft   = 1'b0;
        cfg_dest    = {LEAF, PORT};
        cfg_en      = 1'b0;
        din_user2tx = '0;
        vld_user2tx = 1'b0;
        credit_in   = '0;
        pkt_rd      = 1'b0;
        next_word   = {$urandom, $urandom};
        repeat (3) @(posedge clk_bft);
        #1;
        check("rst_ack",    128'(ack_tx2user), 128'd0);
        check("rst_pkt",    128'(pkt_out),     128'd0);
        check("rst_empty",  128'(pkt_empty),   128'd1);
        check("rst_credit", 128'(credit_cnt),  128'd128);
        reset_bft = 1'b1;
        @(posedge clk_bft);
        #1;

        // Update at full credit: saturates silently, flags overflow when the check is built in.
        credit_in = UPDATE;
        tick();
        credit_in = '0;
        check("ovf_credit", 128'(credit_cnt), 128'd128);
`ifdef CREDIT_OVERFLOW_CHECK_EN
        check("ovf_flag", 128'(err_credit_ovf), 128'd1);
        repeat (3) tick();
        check("ovf_sticky", 128'(err_credit_ovf), 128'd1);
`endif

        // Drain all initial credit.
        cfg_en     = 1'b1;
        pkt_rd     = 1'b1;
        words_left = 200;
        repeat (150) tick();
        check("t1_pkts",   128'(pkts_seen),   128'd128);
        check("t1_wrap",   128'(exp_addr),    128'd0);
        check("t1_empty",  128'(pkt_empty),   128'd1);
        check("t1_credit", 128'(credit_cnt),  128'd0);
        check("t1_ack",    128'(ack_tx2user), 128'd0);
        check("t1_sb",     128'(sb.size()),   128'd2);

        // One freespace update: 64 more packets, addresses continue from 0.
        credit_in = UPDATE;
        tick();
        credit_in = '0;
        repeat (80) tick();
        check("t2_pkts",   128'(pkts_seen),   128'd192);
        check("t2_addr",   128'(exp_addr),    128'd64);
        check("t2_credit", 128'(credit_cnt),  128'd0);
        check("t2_ack",    128'(ack_tx2user), 128'd0);

        // Load and update in the same cycle at C=10.
        cfg_en     = 1'b0;
        words_left = 200;
        credit_in  = UPDATE;
        tick();
        credit_in = '0;
        check("t3_refill", 128'(credit_cnt), 128'd64);
        cfg_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (credit_cnt == 8'd10) break;
            tick();
        end
        check("t3_c10", 128'(credit_cnt), 128'd10);
        credit_in = UPDATE;
        tick();
        credit_in = '0;
        check("t3_credit", 128'(credit_cnt), 128'd73);

        // Backpressure: held packet stays put, FIFO fills, then back-to-back delivery.
        pkt_rd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_empty", 128'(pkt_empty), 128'd0);
            check("t4_hold_pkt",   128'(pkt_out),   128'(exp_pkt(exp_addr, sb[0])));
            tick();
        end
        check("t4_ack", 128'(ack_tx2user), 128'd0);
        pkt_rd = 1'b1;
        mark   = pkts_seen;
        repeat (30) tick();
        check("t4_rate", 128'(pkts_seen - mark), 128'd30);

        // Reset with words buffered and a packet held.
        pkt_rd = 1'b0;
        repeat (4) tick();
        check("t6_full", 128'(ack_tx2user), 128'd0);
        words_left  = 0;
        vld_user2tx = 1'b0;
        #2;
        reset_bft = 1'b0;
        #1;
        check("t6_empty",  128'(pkt_empty),  128'd1);
        check("t6_credit", 128'(credit_cnt), 128'd128);
`ifdef CREDIT_OVERFLOW_CHECK_EN
        check("t6_ovf", 128'(err_credit_ovf), 128'd0);
`endif
        sb.delete();
        exp_addr = 0;
        @(posedge clk_bft);
        #1;
        reset_bft  = 1'b1;
        pkt_rd     = 1'b1;
        words_left = 5;
        mark       = pkts_seen;
        repeat (10) tick();
        check("t6_pkts", 128'(pkts_seen - mark), 128'd5);
        check("t6_addr", 128'(exp_addr),         128'd5);
        check("t6_sb",   128'(sb.size()),        128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
